abus: RTL and testbench

Address-bus datapath for the 65C02 core. It sits directly downstream of the control sequencer and consumes its 12-bit `ab_op` word every cycle. It owns three register sets: the 16-bit address register (AB), the 16-bit hold/return register (PC) and the 8-bit address-hold latch (AHL). From these plus the data bus, the register-file operand and the branch condition, it forms the next memory address.

---
 rtl/abus.sv | 113 +++++++++++
 tb/tb_abus.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/abus.sv
`default_nettype none
// ============================================================================
//  Module   : abus
//  Purpose  : 65C02 address-bus datapath (AB, PC hold register, AHL latch).
//  Revision : 1.0  initial release
// ============================================================================
module abus (
   input  logic        clk,
   input  logic        reset,
   input  logic        rdy,
   input  logic [11:0] ab_op,
   input  logic [7:0]  DB,
   input  logic [7:0]  REG,
   input  logic        cond,
   output logic [15:0] AB,
   output logic [15:0] PC
);

   localparam logic [3:0] c_ABH_ZERO  = 4'b0000;
   localparam logic [3:0] c_ABH_STACK = 4'b0001;
   localparam logic [3:0] c_ABH_VECT  = 4'b0011;
   localparam logic [3:0] c_ABH_INC   = 4'b0110;
   localparam logic [3:0] c_ABH_DEC   = 4'b0111;
   localparam logic [3:0] c_ABH_PC    = 4'b1010;
   localparam logic [3:0] c_ABH_DB    = 4'b1110;

   logic [15:0] r_ab;
   logic [15:0] r_pc;
   logic [7:0]  r_ahl;

   logic        w_pc_inc;
   logic        w_pc_load;
   logic        w_ahl_load;
   logic [3:0]  w_abh_sel;
   logic [1:0]  w_abl_sel;
   logic [1:0]  w_abl_op;
   logic        w_abl_ci;

   logic [8:0]  w_abl_sum;
   logic        w_c8;
   logic [7:0]  w_abh;
   logic [7:0]  w_abl_a;
   logic [7:0]  w_abl_b;

   assign w_pc_inc   = ab_op[11];
   assign w_pc_load  = ab_op[10];
   assign w_ahl_load = ab_op[9];
   assign w_abh_sel  = ab_op[8:5];
   assign w_abl_sel  = ab_op[4:3];
   assign w_abl_op   = ab_op[2:1];
   assign w_abl_ci   = ab_op[0];

   // Operand pair for the low-byte adder; bit 8 of the sum carries into ABH.
   always_comb begin
      w_abl_a = 8'h00;
      w_abl_b = 8'h00;
      case (w_abl_op)
         2'b00: begin
            w_abl_a = REG;
            w_abl_b = 8'h00;
         end
         2'b01: begin
            w_abl_a = w_abl_sel[0] ? DB : r_ahl;
            w_abl_b = REG;
         end
         2'b10: begin
            w_abl_a = r_pc[7:0];
            w_abl_b = 8'h00;
         end
         default: begin
            w_abl_a = r_ab[7:0];
            w_abl_b = ((w_abl_sel == 2'b11) && cond) ? DB : 8'h00;
         end
      endcase
   end

   assign w_abl_sum = {1'b0, w_abl_a} + {1'b0, w_abl_b} + {8'h00, w_abl_ci};
   assign w_c8      = w_abl_sum[8];

   // Unused select codes fall to page 0 so the register stays deterministic.
   always_comb begin
      w_abh = 8'h00;
      case (w_abh_sel)
         c_ABH_ZERO:  w_abh = 8'h00;
         c_ABH_STACK: w_abh = 8'h01;
         c_ABH_VECT:  w_abh = 8'hFF;
         c_ABH_INC:   w_abh = r_ab[15:8] + {7'h00, w_c8};
         c_ABH_DEC:   w_abh = r_ab[15:8] + 8'hFF + {7'h00, w_c8};
         c_ABH_PC:    w_abh = r_pc[15:8];
         c_ABH_DB:    w_abh = DB + {7'h00, w_c8};
         default:     w_abh = 8'h00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ab  <= 16'h0000;
         r_pc  <= 16'h0000;
         r_ahl <= 8'h00;
      end else if (rdy) begin
         r_ab <= {w_abh, w_abl_sum[7:0]};
         if (w_pc_load)
            r_pc <= r_ab + {15'h0000, w_pc_inc};
         if (w_ahl_load)
            r_ahl <= DB;
      end
   end

   assign AB = r_ab;
   assign PC = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_abus.sv
`default_nettype none
// ============================================================================
//  Module   : tb_abus
//  Purpose  : Table-driven self-checking bench for abus with result queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_abus;

   logic        clk = 1'b0;
   logic        reset;
   logic        rdy;
   logic [11:0] ab_op;
   logic [7:0]  DB;
   logic [7:0]  REG;
   logic        cond;
   logic [15:0] AB;
   logic [15:0] PC;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        rst;
      logic        rdy;
      logic [11:0] op;
      logic [7:0]  db;
      logic [7:0]  rg;
      logic        cond;
      logic [15:0] ab;
      logic [15:0] pc;
   } vec_t;

   vec_t        t1[$];
   vec_t        t2[$];
   logic [31:0] exp_q[$];
   string       name_q[$];

   abus dut (
      .clk   (clk),
      .reset (reset),
      .rdy   (rdy),
      .ab_op (ab_op),
      .DB    (DB),
      .REG   (REG),
      .cond  (cond),
      .AB    (AB),
      .PC    (PC)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input string n, input logic r, input logic e,
                               input logic [11:0] op, input logic [7:0] db,
                               input logic [7:0] rg, input logic c,
                               input logic [15:0] ab, input logic [15:0] pc);
      vec_t v;
      v.name = n; v.rst = r; v.rdy = e; v.op = op; v.db = db; v.rg = rg;
      v.cond = c; v.ab = ab; v.pc = pc;
      return v;
   endfunction

   task automatic check_out();
      logic [31:0] e;
      string       n;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: no expected entry for observed AB=%h PC=%h", AB, PC);
      end else begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         checks++;
         if (AB !== e[31:16]) begin
            errors++;
            $display("FAIL %s AB: got %h expected %h", n, AB, e[31:16]);
         end
         checks++;
         if (PC !== e[15:0]) begin
            errors++;
            $display("FAIL %s PC: got %h expected %h", n, PC, e[15:0]);
         end
      end
   endtask

   task automatic apply(input vec_t v);
      @(negedge clk);
      reset = v.rst;
      rdy   = v.rdy;
      ab_op = v.op;
      DB    = v.db;
      REG   = v.rg;
      cond  = v.cond;
      exp_q.push_back({v.ab, v.pc});
      name_q.push_back(v.name);
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; rdy = 1'b0; ab_op = 12'h000; DB = 8'h00; REG = 8'h00; cond = 1'b0;

      //           name           rst rdy op      db     rg     c     AB        PC
      t1.push_back(mk("rst_rdy0",    1, 0, 12'hFD2, 8'hAA, 8'h55, 1, 16'h0000, 16'h0000));
      t1.push_back(mk("ahl_5a",      0, 1, 12'h200, 8'h5A, 8'h77, 0, 16'h0077, 16'h0000));
      t1.push_back(mk("vector",      0, 1, 12'h079, 8'h00, 8'hFB, 0, 16'hFFFC, 16'h0000));
      t1.push_back(mk("probe_ahl5a", 0, 1, 12'h002, 8'h99, 8'h00, 0, 16'h005A, 16'h0000));
      t1.push_back(mk("ahl_f0",      0, 1, 12'h200, 8'hF0, 8'h34, 0, 16'h0034, 16'h0000));
      t1.push_back(mk("ab_1234",     0, 1, 12'h1C0, 8'h12, 8'h34, 0, 16'h1234, 16'h0000));
      t1.push_back(mk("abs_idx",     0, 1, 12'hFD2, 8'h20, 8'h20, 0, 16'h2110, 16'h1235));
      t1.push_back(mk("probe_ahl20", 0, 1, 12'h002, 8'h99, 8'h00, 0, 16'h0020, 16'h1235));
      t1.push_back(mk("zp_wrap",     0, 1, 12'hE1A, 8'hF0, 8'h20, 0, 16'h0010, 16'h0021));
      t1.push_back(mk("stack_page",  0, 1, 12'h021, 8'h00, 8'hFF, 0, 16'h0100, 16'h0021));
      t1.push_back(mk("ab_1000",     0, 1, 12'h1C0, 8'h10, 8'h00, 0, 16'h1000, 16'h0021));
      t1.push_back(mk("br_back",     0, 1, 12'h6FF, 8'hFE, 8'h00, 1, 16'h0FFF, 16'h1000));
      t1.push_back(mk("ab_10f0",     0, 1, 12'h1C0, 8'h10, 8'hF0, 0, 16'h10F0, 16'h1000));
      t1.push_back(mk("br_fwd",      0, 1, 12'h6DF, 8'h20, 8'h00, 1, 16'h1111, 16'h10F0));
      t1.push_back(mk("ab_10f0b",    0, 1, 12'h1C0, 8'h10, 8'hF0, 0, 16'h10F0, 16'h10F0));
      t1.push_back(mk("br_not_taken",0, 1, 12'h6DF, 8'h20, 8'h00, 0, 16'h10F1, 16'h10F0));

      t2.push_back(mk("probe_stall", 0, 1, 12'h002, 8'h99, 8'h00, 0, 16'h0020, 16'h10F0));
      t2.push_back(mk("pc_page",     0, 1, 12'h145, 8'h00, 8'h00, 0, 16'h10F1, 16'h10F0));
      t2.push_back(mk("ab_abcd",     0, 1, 12'h1C0, 8'hAB, 8'hCD, 0, 16'hABCD, 16'h10F0));
      t2.push_back(mk("inc_no_load", 0, 1, 12'h800, 8'h00, 8'h11, 0, 16'h0011, 16'h10F0));
      t2.push_back(mk("ab_ffff",     0, 1, 12'h1C0, 8'hFF, 8'hFF, 0, 16'hFFFF, 16'h10F0));
      t2.push_back(mk("pc_wrap",     0, 1, 12'hC00, 8'h00, 8'h00, 0, 16'h0000, 16'h0000));
      t2.push_back(mk("ab_5678",     0, 1, 12'h1C0, 8'h56, 8'h78, 0, 16'h5678, 16'h0000));
      t2.push_back(mk("rst_mid",     1, 1, 12'hFD2, 8'h33, 8'h44, 1, 16'h0000, 16'h0000));
      t2.push_back(mk("probe_rst",   0, 1, 12'h002, 8'h99, 8'h00, 0, 16'h0000, 16'h0000));

      foreach (t1[i]) apply(t1[i]);

      // Three stalled cycles with loading opcodes and random operands: all state frozen.
      for (int s = 0; s < 3; s++) begin
         logic [11:0] sop;
         case (s)
            0:       sop = 12'hFD2;
            1:       sop = 12'hE1A;
            default: sop = 12'h079;
         endcase
         apply(mk($sformatf("stall%0d", s), 0, 0, sop, 8'($urandom), 8'($urandom),
                  1'($urandom), 16'h10F1, 16'h10F0));
      end

      foreach (t2[i]) apply(t2[i]);

      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left: %0d entries never compared, expected 0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
